// File: rtl/packet_pkg.sv
// Shared constants and state type for the serial packet transmitter.
package packet_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned BIT_CNT_W       = 3;
  localparam int unsigned MAX_LEN_DEFAULT = 15;

  localparam logic [BYTE_W-1:0] HDR_A = 8'hA5;
  localparam logic [BYTE_W-1:0] HDR_B = 8'hC3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_WAIT = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5
  } tx_state_t;

endpackage

// File: rtl/tx_shifter.sv
// LSB-first byte shifter with bit position counter; zero-fills so the line idles low
// once all eight bits have been shifted out.
module tx_shifter
  import packet_pkg::*;
(
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              shift_en,
  output logic              bit_out,
  output logic              last_bit,
  output logic              pre_last
);

  logic [BYTE_W-1:0]    shift_q;
  logic [BIT_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= load_data;
      cnt_q   <= '0;
    end else if (shift_en) begin
      shift_q <= {1'b0, shift_q[BYTE_W-1:1]};
      cnt_q   <= cnt_q + BIT_CNT_W'(1);
    end
  end

  assign bit_out  = shift_q[0];
  assign last_bit = (cnt_q == BIT_CNT_W'(7));
  assign pre_last = (cnt_q == BIT_CNT_W'(6));

endmodule

// File: rtl/packet_tx.sv
// Serial packet transmitter: header + len payload bytes, LSB first, one bit per clk_50.
// Define PACKET_TX_CHECKSUM_EN to append an XOR checksum byte after the payload.
module packet_tx
  import packet_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic                         clk_50,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         hdr_sel,
  input  logic [$clog2(MAX_LEN+1)-1:0] len,
  input  logic [BYTE_W-1:0]            byte_data,
  input  logic                         byte_valid,
  output logic                         byte_ready,
  output logic                         serial_data,
  output logic                         data_ena,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned LW = $clog2(MAX_LEN+1);

  tx_state_t         state_q, state_d;
  logic [LW-1:0]     rem_q, rem_d;
  logic              ready_d, ena_d, busy_d, done_d;
  logic              sh_load, sh_shift, take_byte, xfer;
  logic [BYTE_W-1:0] sh_data;
  logic              bit_out, last_bit, pre_last;
`ifdef PACKET_TX_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
`endif

  tx_shifter u_shifter (
    .clk_50    (clk_50),
    .reset_n   (reset_n),
    .load      (sh_load),
    .load_data (sh_data),
    .shift_en  (sh_shift),
    .bit_out   (bit_out),
    .last_bit  (last_bit),
    .pre_last  (pre_last)
  );

  // The shifter output is itself a flop and reads 0 whenever no byte is in flight.
  assign serial_data = bit_out;
  assign xfer        = byte_valid & byte_ready;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      byte_ready <= 1'b0;
      data_ena   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef PACKET_TX_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      byte_ready <= ready_d;
      data_ena   <= ena_d;
      busy       <= busy_d;
      done       <= done_d;
`ifdef PACKET_TX_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    ready_d   = 1'b0;
    ena_d     = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_data   = '0;
    take_byte = 1'b0;
`ifdef PACKET_TX_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sh_load = 1'b1;
          sh_data = hdr_sel ? HDR_B : HDR_A;
          rem_d   = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
          state_d = ST_HDR;
          ena_d   = 1'b1;
          busy_d  = 1'b1;
`ifdef PACKET_TX_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_HDR, ST_DATA, ST_CSUM: begin
        busy_d = 1'b1;
        if (!last_bit) begin
          sh_shift = 1'b1;
          ena_d    = 1'b1;
          ready_d  = pre_last && (rem_q != '0);
        end else if (rem_q != '0) begin
          if (xfer) begin
            take_byte = 1'b1;
          end else begin
            sh_shift = 1'b1;
            ready_d  = 1'b1;
            state_d  = ST_WAIT;
          end
        end
`ifdef PACKET_TX_CHECKSUM_EN
        else if (state_q != ST_CSUM) begin
          sh_load = 1'b1;
          sh_data = csum_q;
          ena_d   = 1'b1;
          state_d = ST_CSUM;
        end
`endif
        else begin
          sh_shift = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_WAIT: begin
        busy_d = 1'b1;
        if (xfer) begin
          take_byte = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Accepted payload byte goes straight onto the line next cycle.
    if (take_byte) begin
      sh_load = 1'b1;
      sh_data = byte_data;
      rem_d   = rem_q - LW'(1);
      ena_d   = 1'b1;
      state_d = ST_DATA;
`ifdef PACKET_TX_CHECKSUM_EN
      csum_d  = csum_q ^ byte_data;
`endif
    end
  end

endmodule
